// File: rtl/cnn_pkg.sv
// Shared types and fixed-point helpers for the pooled feature serializer.
package cnn_pkg;

    typedef enum logic [1:0] {
        ACT_ID   = 2'd0,
        ACT_ABS  = 2'd1,
        ACT_RELU = 2'd2
    } act_mode_e;

    typedef enum logic {
        POOL_AVG = 1'b0,
        POOL_MAX = 1'b1
    } pool_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_FINAL,
        ST_EMIT
    } state_e;

    // Reciprocal of the column height in unsigned Q(n_size), rounded to nearest.
    function automatic int recip(input int height, input int n_size);
        return ((1 << n_size) + height / 2) / height;
    endfunction

    function automatic longint sat_word(input longint v, input int width);
        longint hi;
        longint lo;
        hi = (longint'(1) << (width - 1)) - longint'(1);
        lo = -hi - longint'(1);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/pool_lane.sv
// One channel: activation, average/max accumulator and final scaling with saturation.
module pool_lane
    import cnn_pkg::*;
#(
    parameter int WORD_SIZE    = 16,
    parameter int INT_BITS     = 4,
    parameter int LAYER_HEIGHT = 13
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 clear_i,
    input  logic                 accum_i,
    input  logic                 first_i,
    input  logic                 final_i,
    input  logic [1:0]           act_mode_i,
    input  logic                 pool_mode_i,
    input  logic [WORD_SIZE-1:0] word_i,
    output logic [WORD_SIZE-1:0] result_o
);

    localparam int N_SIZE = WORD_SIZE - INT_BITS;
    localparam int AW     = WORD_SIZE + $clog2(LAYER_HEIGHT);
    localparam int PW     = AW + WORD_SIZE + 1;
    localparam logic [WORD_SIZE-1:0] RECIP = WORD_SIZE'(recip(LAYER_HEIGHT, N_SIZE));
    localparam logic signed [WORD_SIZE-1:0] W_MAX = {1'b0, {(WORD_SIZE-1){1'b1}}};
    localparam logic signed [WORD_SIZE-1:0] W_MIN = {1'b1, {(WORD_SIZE-1){1'b0}}};

    logic signed [WORD_SIZE-1:0] word_s;
    logic signed [WORD_SIZE-1:0] act;
    logic signed [AW-1:0]        act_ext;
    logic signed [AW-1:0]        acc_q, acc_d;
    logic signed [PW-1:0]        prod;
    logic signed [PW-1:0]        scaled;
    logic [WORD_SIZE-1:0]        result_q, result_d;

    assign word_s = word_i;

    // abs of the most negative word has no positive twin, so it clips to the maximum.
    always_comb begin
        act = word_s;
        case (act_mode_i)
            ACT_ABS: begin
                if (word_s == W_MIN)
                    act = W_MAX;
                else if (word_s[WORD_SIZE-1])
                    act = -word_s;
            end
            ACT_RELU: begin
                if (word_s[WORD_SIZE-1])
                    act = '0;
            end
            default: act = word_s;
        endcase
    end

    assign act_ext = AW'(act);

    always_comb begin
        acc_d = acc_q;
        if (clear_i) begin
            acc_d = '0;
        end else if (accum_i) begin
            if (pool_mode_i == POOL_MAX)
                acc_d = (first_i || (act_ext > acc_q)) ? act_ext : acc_q;
            else
                acc_d = acc_q + act_ext;
        end
    end

    assign prod   = PW'(acc_q) * PW'($signed({1'b0, RECIP}));
    assign scaled = prod >>> N_SIZE;

    always_comb begin
        result_d = result_q;
        if (final_i) begin
            if (pool_mode_i == POOL_MAX)
                result_d = acc_q[WORD_SIZE-1:0];
            else
                result_d = WORD_SIZE'(sat_word(longint'(scaled), WORD_SIZE));
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign result_o = result_q;

endmodule

// File: rtl/pooled_feature_serializer.sv
// Pools NUM_CHANNELS conv columns per bundle and writes one pooled word per cycle to a FIFO.
// Bundle takes LAYER_HEIGHT+2+NUM_CHANNELS cycles without backpressure; full_i stalls emission.
module pooled_feature_serializer
    import cnn_pkg::*;
#(
    parameter int WORD_SIZE    = 16,
    parameter int INT_BITS     = 4,
    parameter int NUM_CHANNELS = 8,
    parameter int LAYER_HEIGHT = 13
) (
    input  logic                                                  clk_i,
    input  logic                                                  reset_n_i,
    input  logic                                                  valid_i,
    output logic                                                  ready_o,
    input  logic [NUM_CHANNELS-1:0][LAYER_HEIGHT-1:0][WORD_SIZE-1:0] data_i,
    input  logic [1:0]                                            act_mode_i,
    input  logic                                                  pool_mode_i,
    output logic                                                  wen_o,
    input  logic                                                  full_i,
    output logic [WORD_SIZE-1:0]                                  data_o,
    output logic                                                  last_o
);

    localparam int RW = $clog2(LAYER_HEIGHT);
    localparam int CW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [RW-1:0] ROW_LAST = RW'(LAYER_HEIGHT - 1);
    localparam logic [CW-1:0] CH_LAST  = CW'(NUM_CHANNELS - 1);

    state_e                                                 state_q;
    logic                                                   ready_q;
    logic [RW-1:0]                                          row_q;
    logic [CW-1:0]                                          ch_q;
    logic [NUM_CHANNELS-1:0][LAYER_HEIGHT-1:0][WORD_SIZE-1:0] data_q;
    logic [1:0]                                             act_q;
    logic                                                   pool_q;
    logic [NUM_CHANNELS-1:0][WORD_SIZE-1:0]                 res;
    logic                                                   accept;

    assign accept  = valid_i && ready_q && (state_q == ST_IDLE);
    assign ready_o = ready_q;
    assign wen_o   = (state_q == ST_EMIT) && !full_i;
    assign last_o  = wen_o && (ch_q == CH_LAST);
    assign data_o  = (state_q == ST_EMIT) ? res[ch_q] : '0;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            row_q   <= '0;
            ch_q    <= '0;
            data_q  <= '0;
            act_q   <= '0;
            pool_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        data_q  <= data_i;
                        act_q   <= act_mode_i;
                        pool_q  <= pool_mode_i;
                        row_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (row_q == ROW_LAST) begin
                        row_q   <= '0;
                        state_q <= ST_FINAL;
                    end else begin
                        row_q <= row_q + 1'b1;
                    end
                end
                ST_FINAL: begin
                    ch_q    <= '0;
                    state_q <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (wen_o) begin
                        if (ch_q == CH_LAST) begin
                            ch_q    <= '0;
                            ready_q <= 1'b1;
                            state_q <= ST_IDLE;
                        end else begin
                            ch_q <= ch_q + 1'b1;
                        end
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Every lane walks the same row of its own column in lockstep.
    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_lane
        pool_lane #(
            .WORD_SIZE    (WORD_SIZE),
            .INT_BITS     (INT_BITS),
            .LAYER_HEIGHT (LAYER_HEIGHT)
        ) u_lane (
            .clk_i       (clk_i),
            .reset_n_i   (reset_n_i),
            .clear_i     (accept),
            .accum_i     (state_q == ST_ACCUM),
            .first_i     (row_q == '0),
            .final_i     (state_q == ST_FINAL),
            .act_mode_i  (act_q),
            .pool_mode_i (pool_q),
            .word_i      (data_q[c][row_q]),
            .result_o    (res[c])
        );
    end

endmodule

// File: tb/tb_pooled_feature_serializer.sv
// Directed bench for pooled_feature_serializer at default parameters (N_SIZE=12, RECIP=315).
module tb_pooled_feature_serializer;

    localparam int W  = 16;
    localparam int NC = 8;
    localparam int LH = 13;

    logic                            clk_i = 1'b0;
    logic                            reset_n_i;
    logic                            valid_i;
    logic                            ready_o;
    logic [NC-1:0][LH-1:0][W-1:0]    data_i;
    logic [1:0]                      act_mode_i;
    logic                            pool_mode_i;
    logic                            wen_o;
    logic                            full_i;
    logic [W-1:0]                    data_o;
    logic                            last_o;

    int checks   = 0;
    int failures = 0;

    int          got_n, first_cyc, last_cyc, last_cnt, last_idx, orphan_last, ready_mid;
    int          stall_seen, stall_changes, stall_wen;
    int          bp_after = -1;
    int          bp_left  = 0;
    logic [W-1:0] stall_first_dat;
    logic [W-1:0] got_w [0:15];
    logic        timed_out, ready_after;

    always #5 clk_i = ~clk_i;

    pooled_feature_serializer #(
        .WORD_SIZE(W), .INT_BITS(4), .NUM_CHANNELS(NC), .LAYER_HEIGHT(LH)
    ) dut (
        .clk_i       (clk_i),
        .reset_n_i   (reset_n_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .data_i      (data_i),
        .act_mode_i  (act_mode_i),
        .pool_mode_i (pool_mode_i),
        .wen_o       (wen_o),
        .full_i      (full_i),
        .data_o      (data_o),
        .last_o      (last_o)
    );

    task automatic fill_const(input logic [W-1:0] v);
        for (int c = 0; c < NC; c++)
            for (int r = 0; r < LH; r++)
                data_i[c][r] = v;
    endtask

    task automatic fill_ramp();
        for (int c = 0; c < NC; c++)
            for (int r = 0; r < LH; r++)
                data_i[c][r] = (r == 5) ? 16'h7000 : W'(r * 256);
    endtask

    task automatic fill_min_row0();
        for (int c = 0; c < NC; c++)
            for (int r = 0; r < LH; r++)
                data_i[c][r] = (r == 0) ? 16'h8000 : 16'h0000;
    endtask

    // Accepts one bundle, then scrambles the inputs and records every write with its cycle.
    task automatic run_bundle(input logic [1:0] am, input logic pm, input logic keep);
        int  cyc;
        bit  done;
        got_n = 0; first_cyc = -1; last_cyc = -1; last_cnt = 0; last_idx = -1;
        orphan_last = 0; ready_mid = 0; stall_seen = 0; stall_changes = 0; stall_wen = 0;
        stall_first_dat = 'x; timed_out = 1'b0; done = 0;
        for (int i = 0; i < 16; i++) got_w[i] = 'x;
        act_mode_i = am; pool_mode_i = pm; valid_i = 1'b1;
        @(posedge clk_i); #1;
        valid_i = keep; act_mode_i = 2'd2; pool_mode_i = ~pm; fill_const(16'h7123);
        cyc = 1;
        while (!done && cyc < 200) begin
            if (got_n == bp_after && bp_left > 0) begin
                full_i = 1'b1; bp_left--;
            end else begin
                full_i = 1'b0;
            end
            #1;
            if (ready_o) ready_mid++;
            if (last_o && !wen_o) orphan_last++;
            if (full_i) begin
                if (stall_seen == 0) stall_first_dat = data_o;
                else if (data_o !== stall_first_dat) stall_changes++;
                if (wen_o) stall_wen++;
                stall_seen++;
            end
            if (wen_o) begin
                if (got_n < 16) got_w[got_n] = data_o;
                if (got_n == 0) first_cyc = cyc;
                if (last_o) begin
                    last_cnt++; last_idx = got_n; last_cyc = cyc; done = 1;
                end
                got_n++;
            end
            @(posedge clk_i); #1;
            cyc++;
        end
        full_i = 1'b0;
        if (!done) timed_out = 1'b1;
        #1;
        ready_after = ready_o;
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0; valid_i = 1'b0; full_i = 1'b0;
        act_mode_i = 2'd0; pool_mode_i = 1'b0; fill_const(16'h0000);
        #12;
        full_i = 1'b0;
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
        checks++; if (wen_o !== 1'b0) begin failures++; $display("FAIL reset_wen got=%b exp=0", wen_o); end
        checks++; if (data_o !== 16'h0000) begin failures++; $display("FAIL reset_data got=%h exp=0000", data_o); end
        checks++; if (last_o !== 1'b0) begin failures++; $display("FAIL reset_last got=%b exp=0", last_o); end
        @(negedge clk_i); reset_n_i = 1'b1;
        @(posedge clk_i); #1;
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%b exp=1", ready_o); end
    endtask

    task automatic test_abs_avg();
        fill_const(16'h1000);
        run_bundle(2'd1, 1'b0, 1'b0);
        checks++; if (timed_out !== 1'b0) begin failures++; $display("FAIL abs_avg_timeout got=%b exp=0", timed_out); end
        checks++; if (got_n !== 8) begin failures++; $display("FAIL abs_avg_writes got=%0d exp=8", got_n); end
        for (int i = 0; i < NC; i++) begin
            checks++;
            if (got_w[i] !== 16'h0FFF) begin failures++; $display("FAIL abs_avg_word%0d got=%h exp=0fff", i, got_w[i]); end
        end
        checks++; if (first_cyc !== 15) begin failures++; $display("FAIL abs_avg_first_wen got=%0d exp=15", first_cyc); end
        checks++; if (last_cyc !== 22) begin failures++; $display("FAIL abs_avg_last_cycle got=%0d exp=22", last_cyc); end
        checks++; if (last_cnt !== 1 || last_idx !== 7) begin failures++; $display("FAIL abs_avg_last got=%0d@%0d exp=1@7", last_cnt, last_idx); end
        checks++; if (orphan_last !== 0) begin failures++; $display("FAIL abs_avg_orphan_last got=%0d exp=0", orphan_last); end
        checks++; if (ready_mid !== 0) begin failures++; $display("FAIL abs_avg_ready_busy got=%0d exp=0", ready_mid); end
        checks++; if (ready_after !== 1'b1) begin failures++; $display("FAIL abs_avg_ready_after got=%b exp=1", ready_after); end
    endtask

    task automatic test_id_relu_avg();
        fill_const(16'hF000);
        run_bundle(2'd0, 1'b0, 1'b0);
        checks++; if (got_n !== 8) begin failures++; $display("FAIL id_avg_writes got=%0d exp=8", got_n); end
        for (int i = 0; i < NC; i++) begin
            checks++;
            if (got_w[i] !== 16'hF001) begin failures++; $display("FAIL id_avg_word%0d got=%h exp=f001", i, got_w[i]); end
        end
        fill_const(16'hF000);
        run_bundle(2'd2, 1'b0, 1'b0);
        checks++; if (got_n !== 8) begin failures++; $display("FAIL relu_avg_writes got=%0d exp=8", got_n); end
        for (int i = 0; i < NC; i++) begin
            checks++;
            if (got_w[i] !== 16'h0000) begin failures++; $display("FAIL relu_avg_word%0d got=%h exp=0000", i, got_w[i]); end
        end
    endtask

    task automatic test_max();
        fill_ramp();
        run_bundle(2'd0, 1'b1, 1'b0);
        checks++; if (got_n !== 8) begin failures++; $display("FAIL id_max_writes got=%0d exp=8", got_n); end
        for (int i = 0; i < NC; i++) begin
            checks++;
            if (got_w[i] !== 16'h7000) begin failures++; $display("FAIL id_max_word%0d got=%h exp=7000", i, got_w[i]); end
        end
        fill_min_row0();
        run_bundle(2'd1, 1'b1, 1'b0);
        checks++; if (got_n !== 8) begin failures++; $display("FAIL abs_max_writes got=%0d exp=8", got_n); end
        for (int i = 0; i < NC; i++) begin
            checks++;
            if (got_w[i] !== 16'h7FFF) begin failures++; $display("FAIL abs_max_word%0d got=%h exp=7fff", i, got_w[i]); end
        end
    endtask

    task automatic test_backpressure();
        fill_const(16'h1000);
        bp_after = 3; bp_left = 5;
        run_bundle(2'd1, 1'b0, 1'b0);
        bp_after = -1; bp_left = 0;
        checks++; if (got_n !== 8) begin failures++; $display("FAIL bp_writes got=%0d exp=8", got_n); end
        checks++; if (stall_seen !== 5) begin failures++; $display("FAIL bp_stall_cycles got=%0d exp=5", stall_seen); end
        checks++; if (stall_wen !== 0) begin failures++; $display("FAIL bp_wen_in_stall got=%0d exp=0", stall_wen); end
        checks++; if (stall_first_dat !== 16'h0FFF || stall_changes !== 0) begin
            failures++; $display("FAIL bp_held_data got=%h changes=%0d exp=0fff changes=0", stall_first_dat, stall_changes);
        end
        for (int i = 0; i < NC; i++) begin
            checks++;
            if (got_w[i] !== 16'h0FFF) begin failures++; $display("FAIL bp_word%0d got=%h exp=0fff", i, got_w[i]); end
        end
        checks++; if (last_cyc !== 27) begin failures++; $display("FAIL bp_last_cycle got=%0d exp=27", last_cyc); end
        checks++; if (last_idx !== 7 || last_cnt !== 1) begin failures++; $display("FAIL bp_last got=%0d@%0d exp=1@7", last_cnt, last_idx); end
    endtask

    task automatic test_reset_abort();
        int wr;
        fill_const(16'h1000);
        act_mode_i = 2'd1; pool_mode_i = 1'b0; valid_i = 1'b1; full_i = 1'b0;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        repeat (6) @(posedge clk_i);
        #1;
        reset_n_i = 1'b0;
        #1;
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL abort_ready got=%b exp=1", ready_o); end
        checks++; if (wen_o !== 1'b0) begin failures++; $display("FAIL abort_wen got=%b exp=0", wen_o); end
        checks++; if (data_o !== 16'h0000) begin failures++; $display("FAIL abort_data got=%h exp=0000", data_o); end
        checks++; if (last_o !== 1'b0) begin failures++; $display("FAIL abort_last got=%b exp=0", last_o); end
        @(posedge clk_i); #3;
        reset_n_i = 1'b1;
        wr = 0;
        repeat (30) begin
            @(posedge clk_i); #2;
            if (wen_o || last_o) wr++;
        end
        checks++; if (wr !== 0) begin failures++; $display("FAIL abort_no_writes got=%0d exp=0", wr); end
        checks++; if (ready_o !== 1'b1) begin failures++; $display("FAIL abort_idle_ready got=%b exp=1", ready_o); end
        fill_const(16'h1000);
        run_bundle(2'd1, 1'b0, 1'b0);
        checks++; if (got_n !== 8) begin failures++; $display("FAIL abort_next_writes got=%0d exp=8", got_n); end
        for (int i = 0; i < NC; i++) begin
            checks++;
            if (got_w[i] !== 16'h0FFF) begin failures++; $display("FAIL abort_next_word%0d got=%h exp=0fff", i, got_w[i]); end
        end
    endtask

    task automatic test_back_to_back();
        fill_const(16'h1000);
        run_bundle(2'd1, 1'b0, 1'b1);
        checks++; if (ready_mid !== 0) begin failures++; $display("FAIL b2b_early_accept got=%0d exp=0", ready_mid); end
        checks++; if (ready_after !== 1'b1) begin failures++; $display("FAIL b2b_ready_after_last got=%b exp=1", ready_after); end
        for (int i = 0; i < NC; i++) begin
            checks++;
            if (got_w[i] !== 16'h0FFF) begin failures++; $display("FAIL b2b_first_word%0d got=%h exp=0fff", i, got_w[i]); end
        end
        fill_const(16'hF000);
        run_bundle(2'd0, 1'b0, 1'b0);
        checks++; if (first_cyc !== 15) begin failures++; $display("FAIL b2b_second_first_wen got=%0d exp=15", first_cyc); end
        for (int i = 0; i < NC; i++) begin
            checks++;
            if (got_w[i] !== 16'hF001) begin failures++; $display("FAIL b2b_second_word%0d got=%h exp=f001", i, got_w[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_abs_avg();
        test_id_relu_avg();
        test_max();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
